// File: rtl/alg_mc_if.sv
// alg_mc_if: operand/result handshake bundle for the alg_mc multi-cycle ALU.
//   a, b, op, in_valid : operands and opcode offered by the front end
//   in_ready           : unit can accept a new operation
//   out, err           : 2*WIDTH result and divide-by-zero flag
//   out_valid          : result valid; out_ready accepts it
//   busy               : unit is iterating a mul/div/mod
// master = operand/result consumer side, slave = the ALU.
interface alg_mc_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         op;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] out;
    logic               err;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, out, err, out_valid, busy
    );

    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, out, err, out_valid, busy
    );
endinterface

// File: rtl/alg_mc.sv
// alg_mc: parametrised multi-cycle ALU (add/sub/and/or/xor single cycle,
// shift-add multiply and restoring divide/modulo one bit per cycle).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alg_mc_if slave port (operands, opcode, handshakes, result, err, busy)
// Operands are captured on accept; the result is held in DONE until taken.
module alg_mc #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    alg_mc_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_DIV = 3'b110,
        OP_MOD = 3'b111
    } op_e;

    state_e             state;
    op_e                op_r;
    op_e                op_in;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;    // mul: running product; div: remainder in low bits
    logic [2*WIDTH-1:0] mcand;  // mul: multiplicand, shifted left each step
    logic [WIDTH-1:0]   mplr;   // mul: multiplier (LSB first); div: dividend -> quotient
    logic [WIDTH-1:0]   dsor;

    logic [2*WIDTH-1:0] quick;
    logic               quick_err;
    logic               quick_done;

    logic [2*WIDTH-1:0] acc_mul_nx;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;

    assign op_in        = op_e'(bus.op);
    assign bus.in_ready = (state == IDLE) && !rst;
    assign bus.busy     = (state == CALC);

    // Single-cycle results, including the divide-by-zero shortcuts.
    always_comb begin
        quick      = '0;
        quick_err  = 1'b0;
        quick_done = 1'b1;
        case (op_in)
            OP_ADD: quick = {{WIDTH{1'b0}}, bus.a} + {{WIDTH{1'b0}}, bus.b};
            OP_SUB: quick = {{WIDTH{1'b0}}, bus.a} - {{WIDTH{1'b0}}, bus.b};
            OP_AND: quick = {{WIDTH{1'b0}}, bus.a & bus.b};
            OP_OR:  quick = {{WIDTH{1'b0}}, bus.a | bus.b};
            OP_XOR: quick = {{WIDTH{1'b0}}, bus.a ^ bus.b};
            OP_MUL: quick_done = 1'b0;
            OP_DIV: begin
                if (bus.b == '0) begin
                    quick     = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                    quick_err = 1'b1;
                end else begin
                    quick_done = 1'b0;
                end
            end
            OP_MOD: begin
                if (bus.b == '0) begin
                    quick     = {{WIDTH{1'b0}}, bus.a};
                    quick_err = 1'b1;
                end else begin
                    quick_done = 1'b0;
                end
            end
            default: quick_done = 1'b1;
        endcase
    end

    // One iteration step for multiply and restoring divide.
    always_comb begin
        acc_mul_nx = mplr[0] ? acc + mcand : acc;
        // bring down next dividend bit (MSB first) and trial-subtract
        shifted    = {acc[WIDTH-1:0], mplr[WIDTH-1]};
        ge         = (shifted >= {1'b0, dsor});
        diff       = shifted - {1'b0, dsor};
        rem_nx     = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nx     = {mplr[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op_r          <= OP_ADD;
            cnt           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplr          <= '0;
            dsor          <= '0;
            bus.out       <= '0;
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_r    <= op_in;
                        bus.err <= quick_err;
                        if (quick_done) begin
                            bus.out       <= quick;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, bus.a};
                            mplr  <= (op_in == OP_MUL) ? bus.b : bus.a;
                            dsor  <= bus.b;
                            cnt   <= CW'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (op_r == OP_MUL) begin
                        acc   <= acc_mul_nx;
                        mcand <= mcand << 1;
                        mplr  <= mplr >> 1;
                    end else begin
                        acc  <= {{WIDTH{1'b0}}, rem_nx};
                        mplr <= quo_nx;
                    end
                    // last step: register the freshly computed value directly
                    if (cnt == CW'(1)) begin
                        if (op_r == OP_MUL)
                            bus.out <= acc_mul_nx;
                        else if (op_r == OP_DIV)
                            bus.out <= {{WIDTH{1'b0}}, quo_nx};
                        else
                            bus.out <= {{WIDTH{1'b0}}, rem_nx};
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
